// File: rtl/tag_merge_arb.sv
// tag_merge_arb: NIN-input word merge with round-robin / fixed-priority grant,
// message locking until the last word, and a single registered output stage.
module tag_merge_arb #(
  parameter int NIN     = 3,
  parameter int N       = 27,
  parameter int NSRC    = 2,
  parameter int PRIO_HI = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NIN*N-1:0] i_in_d,
  input  logic [NIN-1:0]   i_in_last,
  input  logic [NIN-1:0]   i_in_v,
  output logic [NIN-1:0]   o_in_a,
  input  logic             i_mode_rr,
  output logic [N-1:0]     o_out_d,
  output logic             o_out_last,
  output logic [NSRC-1:0]  o_out_src,
  output logic             o_out_v,
  input  logic             i_out_a,
  output logic             o_locked
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t     r_state;
  logic [NSRC-1:0] r_owner;
  logic [NSRC-1:0] r_rr_ptr;
  logic [N-1:0]    r_out_d;
  logic            r_out_last;
  logic [NSRC-1:0] r_out_src;
  logic            r_out_v;

  logic            w_free;
  logic            w_grant_v;
  logic            w_accept;
  logic            w_sel_last;
  logic [NSRC-1:0] w_grant_idx;
  logic [NSRC-1:0] w_start;
  logic [N-1:0]    w_sel_d;

  // Output stage can take a word when empty or being drained this cycle
  always_comb begin
    w_free   = (!r_out_v) || i_out_a;
    w_accept = w_grant_v && w_free && (!i_reset);
  end

  // Grant search: owner only while locked, otherwise first valid from w_start upward
  always_comb begin
    int idx;
    w_grant_v   = 1'b0;
    w_grant_idx = '0;
    w_start     = '0;
    idx         = 0;
    if (r_state == ST_LOCKED) begin
      w_grant_v   = i_in_v[r_owner];
      w_grant_idx = r_owner;
    end else begin
      if (i_mode_rr) begin
        if (r_rr_ptr == NSRC'(NIN - 1)) begin
          w_start = '0;
        end else begin
          w_start = r_rr_ptr + 1'b1;
        end
      end else begin
        w_start = NSRC'(PRIO_HI);
      end
      // Walk from the farthest candidate back to w_start so the nearest valid wins
      for (int k = NIN - 1; k >= 0; k--) begin
        idx         = int'(w_start) + k;
        idx         = (idx >= NIN) ? (idx - NIN) : idx;
        w_grant_v   = w_grant_v | i_in_v[idx];
        w_grant_idx = i_in_v[idx] ? NSRC'(idx) : w_grant_idx;
      end
    end
  end

  // One-hot ack and data/last selection for the granted channel
  always_comb begin
    o_in_a     = '0;
    w_sel_d    = i_in_d[int'(w_grant_idx) * N +: N];
    w_sel_last = i_in_last[w_grant_idx];
    for (int i = 0; i < NIN; i++) begin
      o_in_a[i] = w_accept && (w_grant_idx == NSRC'(i));
    end
  end

  // Output register, lock state machine and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_UNLOCKED;
      r_owner    <= '0;
      r_rr_ptr   <= NSRC'(NIN - 1);
      r_out_d    <= '0;
      r_out_last <= 1'b0;
      r_out_src  <= '0;
      r_out_v    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_d    <= w_sel_d;
        r_out_last <= w_sel_last;
        r_out_src  <= w_grant_idx;
        r_out_v    <= 1'b1;
        r_rr_ptr   <= w_grant_idx;
        case (r_state)
          ST_UNLOCKED: begin
            if (!w_sel_last) begin
              r_state <= ST_LOCKED;
              r_owner <= w_grant_idx;
            end
          end
          ST_LOCKED: begin
            if (w_sel_last) begin
              r_state <= ST_UNLOCKED;
            end
          end
          default: begin
            r_state <= ST_UNLOCKED;
          end
        endcase
      end else if (r_out_v && i_out_a) begin
        r_out_v <= 1'b0;
      end
    end
  end

  assign o_out_d    = r_out_d;
  assign o_out_last = r_out_last;
  assign o_out_src  = r_out_src;
  assign o_out_v    = r_out_v;
  assign o_locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_tag_merge_arb.sv
// Directed bench for tag_merge_arb: per-channel source queues, a queue-based
// reference model checked every cycle, and literal grant-order expectations.
module tb_tag_merge_arb;

  localparam int NIN     = 3;
  localparam int N       = 27;
  localparam int NSRC    = 2;
  localparam int PRIO_HI = 1;
  localparam int BUDGET  = 60;

  logic             clk = 1'b0;
  logic             reset;
  logic [NIN*N-1:0] in_d;
  logic [NIN-1:0]   in_last;
  logic [NIN-1:0]   in_v;
  logic [NIN-1:0]   in_a;
  logic             mode_rr;
  logic [N-1:0]     out_d;
  logic             out_last;
  logic [NSRC-1:0]  out_src;
  logic             out_v;
  logic             out_a;
  logic             locked;

  tag_merge_arb #(.NIN(NIN), .N(N), .NSRC(NSRC), .PRIO_HI(PRIO_HI)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_d(in_d), .i_in_last(in_last),
    .i_in_v(in_v), .o_in_a(in_a), .i_mode_rr(mode_rr), .o_out_d(out_d),
    .o_out_last(out_last), .o_out_src(out_src), .o_out_v(out_v),
    .i_out_a(out_a), .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           src;
    logic         last;
    logic [N-1:0] d;
  } word_t;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [N:0]     src_q[NIN][$];
  int             log_q[$];
  logic [NIN-1:0] last_acks;

  // reference model: words accepted but not yet consumed, plus arbitration state
  word_t m_q[$];
  int    m_rr    = NIN - 1;
  bit    m_lock  = 1'b0;
  int    m_owner = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] dat(input int ch, input int seq);
    return N'(ch * 256 + seq);
  endfunction

  task automatic push(input int ch, input int seq, input logic last);
    logic [N:0] w;
    w = {last, dat(ch, seq)};
    src_q[ch].push_back(w);
  endtask

  task automatic drive();
    logic [N:0] w;
    for (int i = 0; i < NIN; i++) begin
      if (src_q[i].size() > 0) begin
        w = src_q[i][0];
        in_v[i]          = 1'b1;
        in_last[i]       = w[N];
        in_d[i*N +: N]   = w[N-1:0];
      end else begin
        in_v[i]          = 1'b0;
        in_last[i]       = 1'b0;
        in_d[i*N +: N]   = '0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    last_acks = in_a;
    @(posedge clk);
    #1;
    for (int i = 0; i < NIN; i++) begin
      if (last_acks[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NIN; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic drain(input string name, output int n);
    n = 0;
    while ((pending() > 0 || out_v === 1'b1) && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: drain not complete, got %0d cycles required < %0d", name, n, BUDGET);
    end
  endtask

  task automatic check_log(input string name, input int e[$]);
    check({name, "_len"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) check(name, log_q[i], e[i]);
  endtask

  // Compare process: check outputs against the model, then advance it across the coming edge
  always @(negedge clk) begin
    int             start;
    int             c;
    int             g;
    bit             free;
    logic [NIN-1:0] exp_a;
    word_t          w;
    check("out_v", out_v, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_d", out_d, m_q[0].d);
      check("out_last", out_last, m_q[0].last);
      check("out_src", out_src, m_q[0].src);
    end
    check("locked", locked, m_lock);
    free = (m_q.size() == 0) || (out_a == 1'b1);
    g = -1;
    if (m_lock) begin
      if (in_v[m_owner]) g = m_owner;
    end else begin
      start = mode_rr ? (m_rr + 1) % NIN : PRIO_HI;
      for (int k = 0; k < NIN; k++) begin
        c = (start + k) % NIN;
        if (g < 0 && in_v[c]) g = c;
      end
    end
    exp_a = '0;
    if (!reset && free && g >= 0) exp_a[g] = 1'b1;
    check("in_a", in_a, exp_a);
    if (!reset && out_v && out_a) log_q.push_back(int'(out_src));
    if (reset) begin
      m_q.delete();
      m_rr    = NIN - 1;
      m_lock  = 1'b0;
      m_owner = 0;
    end else begin
      if (out_a && m_q.size() > 0) void'(m_q.pop_front());
      if (exp_a != '0) begin
        w.src   = g;
        w.last  = in_last[g];
        w.d     = in_d[g*N +: N];
        m_q.push_back(w);
        m_rr    = g;
        m_lock  = !w.last;
        m_owner = g;
      end
    end
  end

  initial begin
    int n;
    int e[$];
    reset   = 1'b1;
    out_a   = 1'b1;
    mode_rr = 1'b1;
    drive();
    repeat (2) tick();
    check("reset_out_v", out_v, 0);
    check("reset_locked", locked, 0);
    check("reset_out_src", out_src, 0);
    check("reset_out_d", out_d, 0);

    // reset with a word held and a message locked
    push(0, 1, 1'b0);
    reset = 1'b0;
    out_a = 1'b0;
    drive();
    tick();
    check("pre_rst_out_v", out_v, 1);
    check("pre_rst_locked", locked, 1);
    reset = 1'b1;
    push(0, 2, 1'b1);
    push(1, 1, 1'b1);
    push(2, 1, 1'b1);
    drive();
    tick();
    check("rst_in_a", last_acks, 0);
    check("rst_out_v", out_v, 0);
    check("rst_locked", locked, 0);
    reset = 1'b0;
    out_a = 1'b1;
    drive();
    log_q.delete();
    tick();
    check("first_grant_src", out_src, 0);
    check("first_grant_v", out_v, 1);
    drain("rst_drain", n);
    e = '{0, 1, 2};
    check_log("rst_seq", e);

    // round-robin fairness with single-word messages
    log_q.delete();
    for (int s = 10; s < 12; s++) for (int ch = 0; ch < NIN; ch++) push(ch, s, 1'b1);
    drive();
    drain("rr_drain", n);
    check("rr_cycles", n, 7);
    e = '{0, 1, 2, 0, 1, 2};
    check_log("rr_seq", e);

    // fixed priority from channel 1, wrapping upward once it runs dry
    mode_rr = 1'b0;
    log_q.delete();
    push(0, 20, 1'b1); push(0, 21, 1'b1);
    push(1, 20, 1'b1); push(1, 21, 1'b1); push(1, 22, 1'b1);
    push(2, 20, 1'b1); push(2, 21, 1'b1);
    drive();
    drain("fp_drain", n);
    check("fp_cycles", n, 8);
    e = '{1, 1, 1, 2, 2, 0, 0};
    check_log("fp_seq", e);

    // message lock: channel 0 three-word message while 1 and 2 wait
    mode_rr = 1'b1;
    push(2, 30, 1'b1);
    drive();
    drain("lock_pre", n);
    log_q.delete();
    push(0, 31, 1'b0); push(0, 32, 1'b0); push(0, 33, 1'b1);
    push(1, 31, 1'b1); push(2, 31, 1'b1);
    drive();
    tick();
    check("lock_1", locked, 1);
    check("lock_1_src", out_src, 0);
    tick();
    check("lock_2", locked, 1);
    check("lock_2_src", out_src, 0);
    tick();
    check("lock_3", locked, 0);
    check("lock_3_src", out_src, 0);
    drain("lock_drain", n);
    e = '{0, 0, 0, 1, 2};
    check_log("lock_seq", e);

    // backpressure: stage holds for 5 cycles, then consume and reload on one edge
    log_q.delete();
    out_a = 1'b0;
    push(0, 40, 1'b1);
    push(1, 40, 1'b1);
    drive();
    tick();
    check("bp_load", out_d, dat(0, 40));
    repeat (5) begin
      tick();
      check("bp_hold_d", out_d, dat(0, 40));
      check("bp_hold_in_a", last_acks, 0);
    end
    out_a = 1'b1;
    drive();
    tick();
    check("bp_next_v", out_v, 1);
    check("bp_next_src", out_src, 1);
    check("bp_next_d", out_d, dat(1, 40));
    drain("bp_drain", n);
    e = '{0, 1};
    check_log("bp_seq", e);

    // reset in the middle of a channel 2 message
    push(2, 50, 1'b0); push(2, 51, 1'b0); push(2, 52, 1'b1);
    drive();
    tick();
    tick();
    check("mm_locked", locked, 1);
    check("mm_src", out_src, 2);
    check("mm_d", out_d, dat(2, 51));
    reset = 1'b1;
    push(0, 50, 1'b1);
    drive();
    tick();
    check("mm_out_v", out_v, 0);
    check("mm_unlocked", locked, 0);
    reset = 1'b0;
    drive();
    log_q.delete();
    tick();
    check("mm_first_src", out_src, 0);
    drain("mm_drain", n);
    e = '{0, 2};
    check_log("mm_seq", e);
    check("mm_end_locked", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
